// File: rtl/vend_ctrl.sv
// ---------------------------------------------------------------------------
// vend_ctrl : coin-key front end and status mirror for a vending FSM.
//
// This block does the following:
//   - Synchronizes and debounces two active-low coin buttons.
//   - Queues one press per key and issues single-cycle coin pulses, with a
//     guaranteed idle gap between pulses. Key1 has priority.
//   - Mirrors the machine credit (in half-units) and counts completed sales.
//   - Holds the last nonzero change code on an LED output for a fixed time.
//
// Parameters:
//   CNT_MAX  - number of stable-low cycles that makes a valid press
//   GAP_CYC  - number of idle cycles after each issued pulse (1..15)
//   HOLD_MAX - change indicator is held for HOLD_MAX+1 cycles
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   key_in[1:0] in   raw buttons, active low (bit0 half, bit1 one)
//   po_money_i  in   change code from vending FSM (00 none, 01 half, 10 one)
//   key1_o      out  half-unit coin pulse
//   key2_o      out  one-unit coin pulse
//   change_led  out  latched change code
//   sale_pulse  out  one-cycle pulse per completed sale
//   sale_cnt    out  completed-sale count, modulo 256
//   credit      out  mirrored credit in half-units, 0..4
// ---------------------------------------------------------------------------
module vend_ctrl #(
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [3:0]  GAP_CYC  = 4'd2,
  parameter logic [24:0] HOLD_MAX = 25'd24_999_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_in,
  input  logic [1:0] po_money_i,
  output logic       key1_o,
  output logic       key2_o,
  output logic [1:0] change_led,
  output logic       sale_pulse,
  output logic [7:0] sale_cnt,
  output logic [2:0] credit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Input synchronizers and debounce state
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0][19:0] cnt_q, cnt_d;
  logic [1:0]       press_q, press_d;

  // Pending bits and issue FSM
  logic [1:0] pend_q, pend_d;
  logic [1:0] clr_s;
  state_e     state_q, state_d;
  logic       sel_q, sel_d;          // 0: key1, 1: key2
  logic [3:0] gap_q, gap_d;
  logic       key1_q, key1_d, key2_q, key2_d;
  logic       arb_go_s, arb_sel_s;

  // Credit mirror and sale counter
  logic [2:0] credit_q, credit_d;
  logic       sale_q, sale_d;
  logic [7:0] sale_cnt_q, sale_cnt_d;
  logic [3:0] sum_s, v_s;

  // Change indicator
  logic [1:0]  led_q, led_d;
  logic [24:0] hold_q, hold_d;

  // Two-flop synchronizer. Idle (released) keys read as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce counters. Each counter saturates at CNT_MAX, so the press flag
  // fires only on the single increment from CNT_MAX-1.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k]) begin
        cnt_d[k] = 20'd0;
      end else if (cnt_q[k] != CNT_MAX) begin
        cnt_d[k]   = cnt_q[k] + 20'd1;
        press_d[k] = (cnt_q[k] == (CNT_MAX - 20'd1));
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Debounce counter and press flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      press_q <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Arbitration: key1 wins when both keys are pending.
  assign arb_go_s  = pend_q[0] | pend_q[1];
  assign arb_sel_s = ~pend_q[0];

  // Issue FSM next-state logic. The last GAP cycle arbitrates directly, so
  // back-to-back pulses are exactly GAP_CYC+1 cycles apart. IDLE is entered
  // only when nothing is pending.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
    clr_s   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (arb_go_s) begin
          state_d = ST_ISSUE;
          sel_d   = arb_sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (sel_q) begin
          clr_s = 2'b10;
        end else begin
          clr_s = 2'b01;
        end
        state_d = ST_GAP;
        gap_d   = 4'd1;
      end
      ST_GAP: begin
        if (gap_q >= GAP_CYC) begin
          gap_d = 4'd0;
          if (arb_go_s) begin
            state_d = ST_ISSUE;
            sel_d   = arb_sel_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = 4'd0;
      end
    endcase
    // A new press in the same cycle as the clear wins.
    pend_d = press_q | (pend_q & ~clr_s);
    key1_d = (state_d == ST_ISSUE) && !sel_d;
    key2_d = (state_d == ST_ISSUE) &&  sel_d;
  end

  // Issue FSM registers. Key outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      gap_q   <= 4'd0;
      pend_q  <= 2'b00;
      key1_q  <= 1'b0;
      key2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      key1_q  <= key1_d;
      key2_q  <= key2_d;
    end
  end

  // Credit mirror. The update happens during the ISSUE cycle, so credit and
  // sale_pulse change together on the following cycle.
  always_comb begin
    credit_d   = credit_q;
    sale_d     = 1'b0;
    sale_cnt_d = sale_cnt_q;
    v_s        = sel_q ? 4'd2 : 4'd1;
    sum_s      = {1'b0, credit_q} + v_s;
    if (state_q == ST_ISSUE) begin
      if (sum_s >= 4'd5) begin
        credit_d   = 3'd0;
        sale_d     = 1'b1;
        sale_cnt_d = sale_cnt_q + 8'd1;
      end else begin
        credit_d = sum_s[2:0];
      end
    end else begin
      credit_d = credit_q;
    end
  end

  // Credit and sale registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q   <= 3'd0;
      sale_q     <= 1'b0;
      sale_cnt_q <= 8'd0;
    end else begin
      credit_q   <= credit_d;
      sale_q     <= sale_d;
      sale_cnt_q <= sale_cnt_d;
    end
  end

  // Change indicator. Any nonzero code (including 11) reloads and restarts
  // the hold.
  always_comb begin
    led_d  = led_q;
    hold_d = hold_q;
    if (po_money_i != 2'b00) begin
      led_d  = po_money_i;
      hold_d = 25'd0;
    end else if (led_q != 2'b00) begin
      if (hold_q == HOLD_MAX) begin
        led_d  = 2'b00;
        hold_d = 25'd0;
      end else begin
        hold_d = hold_q + 25'd1;
      end
    end else begin
      hold_d = 25'd0;
    end
  end

  // Change indicator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= 2'b00;
      hold_q <= 25'd0;
    end else begin
      led_q  <= led_d;
      hold_q <= hold_d;
    end
  end

  assign key1_o     = key1_q;
  assign key2_o     = key2_q;
  assign sale_pulse = sale_q;
  assign sale_cnt   = sale_cnt_q;
  assign credit     = credit_q;
  assign change_led = led_q;

endmodule
